// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on refclk: power-up reset, lock timeout with bounded retries, stability qualification.
// Optional RUN-state lock dropout filter enabled by defining LOCK_GLITCH_FILTER_EN.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 7,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned GLITCH_CYCLES = 4
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             extlock,
    output logic             pll_reset,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] loss_count
);

    localparam int unsigned T_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned T_B  = (STABLE_CYCLES > GLITCH_CYCLES) ? STABLE_CYCLES : GLITCH_CYCLES;
    localparam int unsigned TMAX = (T_A > T_B) ? T_A : T_B;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK sample that enters STABLE is the first locked cycle, so STABLE
    // itself needs STABLE_CYCLES-1 more (STABLE_CYCLES >= 2 assumed).
    localparam logic [TW-1:0] STABLE_LAST  = TW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
    localparam logic [TW-1:0] GLITCH_LAST  = TW'((GLITCH_CYCLES > 0) ? GLITCH_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RST_ASSERT,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t           state, state_next;
    logic [TW-1:0]    timer, timer_next;
    logic [CNT_W-1:0] retry_next, loss_next;
    logic             pll_reset_next, ready_next, fail_next;
    logic             sync_meta, lock_s;

    always_ff @(posedge refclk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sync_meta <= extlock;
            lock_s    <= sync_meta;
        end
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state       <= RST_ASSERT;
            timer       <= '0;
            retry_count <= '0;
            loss_count  <= '0;
            pll_reset   <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            retry_count <= retry_next;
            loss_count  <= loss_next;
            pll_reset   <= pll_reset_next;
            ready       <= ready_next;
            fail        <= fail_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        retry_next = retry_count;
        loss_next  = loss_count;

        case (state)
            RST_ASSERT: begin
                if (timer == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = STABLE;
                    timer_next = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_next = (retry_count == '1) ? retry_count : retry_count + CNT_W'(1);
                    timer_next = '0;
                    if (MAX_RETRIES != 0 && retry_next == RETRY_LIMIT) begin
                        state_next = FAIL;
                    end else begin
                        state_next = RST_ASSERT;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (timer == STABLE_LAST) begin
                    state_next = RUN;
                    timer_next = '0;
                    retry_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
                // timer doubles as the consecutive lock-low counter while in RUN
                if (lock_s) begin
                    timer_next = '0;
                end else if (timer == GLITCH_LAST) begin
                    state_next = RST_ASSERT;
                    timer_next = '0;
                    loss_next  = (loss_count == '1) ? loss_count : loss_count + CNT_W'(1);
                end else begin
                    timer_next = timer + TW'(1);
                end
`else
                if (!lock_s) begin
                    state_next = RST_ASSERT;
                    timer_next = '0;
                    loss_next  = (loss_count == '1) ? loss_count : loss_count + CNT_W'(1);
                end
`endif
            end
            FAIL: begin
                state_next = FAIL;
            end
            default: begin
                state_next = RST_ASSERT;
                timer_next = '0;
            end
        endcase

        pll_reset_next = (state_next == RST_ASSERT) || (state_next == FAIL);
        fail_next      = (state_next == FAIL);
        ready_next     = (state == RUN) && (state_next == RUN);
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor; expectations follow the build's LOCK_GLITCH_FILTER_EN setting.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       reset;
    logic       extlock;
    logic       pll_reset;
    logic       ready;
    logic       fail;
    logic [7:0] retry_count;
    logic [7:0] loss_count;

    int checks = 0;
    int errors = 0;
    int n;
    logic saw;
    logic ok;

    pll_lock_supervisor #(
        .RST_CYCLES   (16),
        .LOCK_TIMEOUT (4096),
        .STABLE_CYCLES(256),
        .MAX_RETRIES  (7),
        .CNT_W        (8),
        .GLITCH_CYCLES(4)
    ) dut (
        .refclk     (refclk),
        .reset      (reset),
        .extlock    (extlock),
        .pll_reset  (pll_reset),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts samples (current one included) while pll_reset stays at level.
    task automatic pll_reset_width(input logic level, input int limit, output int cnt);
        cnt = 0;
        while (pll_reset === level && cnt < limit) begin
            cnt++;
            @(negedge refclk);
        end
    endtask

    // Counts edges until ready reaches level; notes any pll_reset seen meanwhile.
    task automatic wait_ready(input logic level, input int limit, output int cnt, output logic prst);
        cnt  = 0;
        prst = 1'b0;
        while (ready !== level && cnt < limit) begin
            @(negedge refclk);
            cnt++;
            if (pll_reset) prst = 1'b1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"}, pll_reset, 1);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_retry"}, retry_count, 0);
        check({tag, "_loss"}, loss_count, 0);
    endtask

    initial begin
        reset   = 1'b1;
        extlock = 1'b0;
        repeat (5) @(negedge refclk);
        check_reset_values("por");

        // Power-up acquisition
        reset = 1'b0;
        pll_reset_width(1'b1, 100, n);
        check("pwrup_rst_len", n, 16);
        repeat (84) @(negedge refclk);
        extlock = 1'b1;
        wait_ready(1'b1, 1000, n, saw);
        check("pwrup_ready_lat", n, 259);
        check("pwrup_prst_seen", saw, 0);
        check("pwrup_retry", retry_count, 0);
        check("pwrup_fail", fail, 0);

        // Lock loss in RUN
        extlock = 1'b0;
`ifdef LOCK_GLITCH_FILTER_EN
        ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge refclk);
            if (!ready) ok = 1'b0;
            if (i == 2) extlock = 1'b1;
        end
        check("glitch3_ready_held", ok, 1);
        check("glitch3_loss", loss_count, 0);
        extlock = 1'b0;
        repeat (4) @(negedge refclk);
        check("glitch4_ready_f3", ready, 1);
        extlock = 1'b1;
        @(negedge refclk);
        check("glitch4_ready_f4", ready, 1);
        @(negedge refclk);
        check("glitch4_ready_f5", ready, 0);
`else
        @(negedge refclk);
        extlock = 1'b1;
        wait_ready(1'b0, 50, n, saw);
        check("loss_ready_lat", n + 1, 3);
`endif
        check("loss_count", loss_count, 1);
        pll_reset_width(1'b1, 100, n);
        check("loss_rst_len", n, 16);
        wait_ready(1'b1, 1000, n, saw);
        check("relock_ready_lat", n, 257);
        check("relock_retry", retry_count, 0);
        check("relock_loss", loss_count, 1);

        // Reset in RUN clears loss_count; then unstable lock
        reset   = 1'b1;
        extlock = 1'b0;
        @(negedge refclk);
        check_reset_values("run_rst");
        reset = 1'b0;
        pll_reset_width(1'b1, 100, n);
        check("unstab_rst_len", n, 16);
        repeat (20) @(negedge refclk);
        extlock = 1'b1;
        repeat (100) @(negedge refclk);
        check("unstab_not_ready", ready, 0);
        extlock = 1'b0;
        @(negedge refclk);
        extlock = 1'b1;
        wait_ready(1'b1, 1000, n, saw);
        check("unstab_ready_lat", n, 259);
        check("unstab_prst_seen", saw, 0);
        check("unstab_retry", retry_count, 0);

        // Reset during STABLE
        reset   = 1'b1;
        extlock = 1'b0;
        @(negedge refclk);
        reset = 1'b0;
        pll_reset_width(1'b1, 100, n);
        repeat (20) @(negedge refclk);
        extlock = 1'b1;
        repeat (50) @(negedge refclk);
        check("stable_not_ready", ready, 0);
        check("stable_pll_reset", pll_reset, 0);
        reset = 1'b1;
        @(negedge refclk);
        check_reset_values("stable_rst");
        reset = 1'b0;
        pll_reset_width(1'b1, 100, n);
        check("stable_rst_len", n, 16);
        wait_ready(1'b1, 1000, n, saw);
        check("stable_ready_lat", n, 257);

        // No lock: retries exhaust into FAIL
        reset   = 1'b1;
        extlock = 1'b0;
        @(negedge refclk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("nolock_retry", retry_count, i);
            pll_reset_width(1'b1, 100, n);
            check("nolock_pulse_len", n, 16);
            pll_reset_width(1'b0, 5000, n);
            check("nolock_wait_len", n, 4096);
        end
        check("fail_flag", fail, 1);
        check("fail_pll_reset", pll_reset, 1);
        check("fail_retry", retry_count, 7);
        extlock = 1'b1;
        repeat (300) @(negedge refclk);
        check("fail_sticky", fail, 1);
        check("fail_prst_stuck", pll_reset, 1);
        check("fail_ready", ready, 0);

        // Reset in FAIL restarts the sequence
        reset = 1'b1;
        @(negedge refclk);
        check_reset_values("fail_rst");
        reset = 1'b0;
        pll_reset_width(1'b1, 100, n);
        check("fail_rst_len", n, 16);
        wait_ready(1'b1, 1000, n, saw);
        check("fail_rst_ready_lat", n, 257);
        check("fail_rst_fail", fail, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
